// File: rtl/fc_controller.sv
// -----------------------------------------------------------------------------
// fc_controller
//   Sequences the ternary fully-connected MAC (fc_layer) of the MNIST classifier
//   head. For each of N_OUT neurons it streams N_IN (feature, weight) pairs from
//   a synchronous feature RAM and weight ROM into fc_layer. It waits for the
//   saturated int8 score, publishes it on a result stream and tracks the
//   running argmax. The predicted class is reported when the last neuron is done.
//
// Ports
//   clk, resetn               clock, synchronous active-low reset
//   i_start                   start one inference (sampled only when idle)
//   o_feat_addr / i_feat_data feature RAM address / data (1-cycle latency)
//   o_wgt_addr  / i_wgt_data  weight ROM address / data (1-cycle latency)
//   o_fc_data, o_fc_weight,
//   o_fc_valid                beat stream into fc_layer
//   i_fc_data, i_fc_real      fc_layer score and result-ready level
//   o_res_valid/idx/data      one pulse per captured neuron score
//   o_busy, o_done            run in progress / end-of-run pulse
//   o_class                   argmax index, valid from o_done to next start
//   o_error                   sticky result timeout flag
// -----------------------------------------------------------------------------
module fc_controller #(
    parameter int N_IN    = 2304,
    parameter int N_OUT   = 10,
    parameter int FADDR_W = 12,
    parameter int WADDR_W = 15,
    parameter int GAP     = 4,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               i_start,
    output logic [FADDR_W-1:0] o_feat_addr,
    input  logic [1:0]         i_feat_data,
    output logic [WADDR_W-1:0] o_wgt_addr,
    input  logic [1:0]         i_wgt_data,
    output logic [1:0]         o_fc_data,
    output logic [1:0]         o_fc_weight,
    output logic               o_fc_valid,
    input  logic [7:0]         i_fc_data,
    input  logic               i_fc_real,
    output logic               o_res_valid,
    output logic [3:0]         o_res_idx,
    output logic [7:0]         o_res_data,
    output logic               o_busy,
    output logic               o_done,
    output logic [3:0]         o_class,
    output logic               o_error
);

    // One counter serves both the drain timeout and the inter-burst gap.
    localparam int CNT_W = $clog2(TIMEOUT + GAP + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_CAPTURE,
        S_GAP,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [FADDR_W-1:0]  k_q, k_d;        // beat index within the neuron
    logic [WADDR_W-1:0]  base_q, base_d;  // n*N_IN, advanced by N_IN per neuron
    logic [3:0]          n_q, n_d;        // current neuron
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                timeout_q, timeout_d;
    logic signed [7:0]   best_q, best_d;
    logic [3:0]          class_q, class_d;
    logic                error_q, error_d;
    logic                valid_q;
    logic                real_q;

    logic                real_rise;
    logic signed [7:0]   score;

    assign real_rise = i_fc_real & ~real_q;
    // A timed-out neuron is reported with the most negative score.
    assign score     = timeout_q ? 8'sh80 : $signed(i_fc_data);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            base_q    <= '0;
            n_q       <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            best_q    <= '0;
            class_q   <= '0;
            error_q   <= 1'b0;
            valid_q   <= 1'b0;
            real_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            base_q    <= base_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            best_q    <= best_d;
            class_q   <= class_d;
            error_q   <= error_d;
            // Memory data returns one cycle after the address, so the beat
            // is valid in the cycle following each ISSUE cycle.
            valid_q   <= (state_q == S_ISSUE);
            real_q    <= i_fc_real;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        base_d    = base_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        best_d    = best_q;
        class_d   = class_q;
        error_d   = error_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d   = S_ISSUE;
                    k_d       = '0;
                    base_d    = '0;
                    n_d       = '0;
                    timeout_d = 1'b0;
                    best_d    = 8'sh80;
                    class_d   = '0;
                    error_d   = 1'b0;
                end
            end
            S_ISSUE: begin
                if (k_q == FADDR_W'(N_IN - 1)) begin
                    k_d     = '0;
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // cnt_q counts cycles since the last valid beat (which is the
                // first DRAIN cycle).
                if (real_rise) begin
                    state_d = S_CAPTURE;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    error_d   = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                // Strict compare: on ties the lower neuron index wins.
                if (score > best_q) begin
                    best_d  = score;
                    class_d = n_q;
                end
                timeout_d = 1'b0;
                if (n_q == 4'(N_OUT - 1)) begin
                    state_d = S_DONE;
                end else begin
                    n_d     = n_q + 1'b1;
                    base_d  = base_q + WADDR_W'(N_IN);
                    cnt_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                // Quiet period so fc_layer's beat counter returns to zero.
                if (cnt_q == CNT_W'(GAP - 1)) begin
                    state_d = S_ISSUE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_feat_addr = k_q;
    assign o_wgt_addr  = base_q + WADDR_W'(k_q);
    assign o_fc_valid  = valid_q;
    // RAM/ROM outputs are already registered by the memories; forwarding
    // them keeps data aligned with o_fc_valid.
    assign o_fc_data   = valid_q ? i_feat_data : 2'b00;
    assign o_fc_weight = valid_q ? i_wgt_data  : 2'b00;
    assign o_res_valid = (state_q == S_CAPTURE);
    assign o_res_idx   = (state_q == S_CAPTURE) ? n_q : 4'd0;
    assign o_res_data  = (state_q == S_CAPTURE) ? score : 8'd0;
    assign o_busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign o_done      = (state_q == S_DONE);
    assign o_class     = class_q;
    assign o_error     = error_q;

endmodule

// File: tb/tb_fc_controller.sv
// -----------------------------------------------------------------------------
// tb_fc_controller
//   Table-driven bench for fc_controller with a reduced N_IN so that every
//   scenario fits a short run. Synchronous memories and a behavioural fc_layer
//   stub surround the DUT. Expected scores come from a plain arithmetic
//   dot-product model over the memory contents.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fc_controller;

    localparam int N_IN    = 160;
    localparam int N_OUT   = 10;
    localparam int FADDR_W = 12;
    localparam int WADDR_W = 15;
    localparam int GAP     = 4;
    localparam int TIMEOUT = 16;
    localparam int FC_LAT  = 4;
    localparam int BUDGET  = 20000;

    localparam int P_ONE  = 0, P_ZERO = 1, P_RAND = 2;
    localparam int W_ONE  = 0, W_ROW  = 1, W_RAND = 2, W_POS = 3;

    typedef struct {
        int fpat;
        int wpat;
        bit never;
        bit spam;
        bit use_model;
        int hi_idx;
        int exp_hi;
        int exp_lo;
        int exp_class;
        bit exp_err;
    } vec_t;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic               i_start = 1'b0;
    logic [FADDR_W-1:0] o_feat_addr;
    logic [1:0]         i_feat_data = 2'b00;
    logic [WADDR_W-1:0] o_wgt_addr;
    logic [1:0]         i_wgt_data = 2'b00;
    logic [1:0]         o_fc_data;
    logic [1:0]         o_fc_weight;
    logic               o_fc_valid;
    logic [7:0]         i_fc_data = 8'd0;
    logic               i_fc_real = 1'b0;
    logic               o_res_valid;
    logic [3:0]         o_res_idx;
    logic [7:0]         o_res_data;
    logic               o_busy;
    logic               o_done;
    logic [3:0]         o_class;
    logic               o_error;

    always #5 clk = ~clk;

    fc_controller #(
        .N_IN(N_IN), .N_OUT(N_OUT), .FADDR_W(FADDR_W), .WADDR_W(WADDR_W),
        .GAP(GAP), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .resetn(resetn), .i_start(i_start),
        .o_feat_addr(o_feat_addr), .i_feat_data(i_feat_data),
        .o_wgt_addr(o_wgt_addr), .i_wgt_data(i_wgt_data),
        .o_fc_data(o_fc_data), .o_fc_weight(o_fc_weight), .o_fc_valid(o_fc_valid),
        .i_fc_data(i_fc_data), .i_fc_real(i_fc_real),
        .o_res_valid(o_res_valid), .o_res_idx(o_res_idx), .o_res_data(o_res_data),
        .o_busy(o_busy), .o_done(o_done), .o_class(o_class), .o_error(o_error)
    );

    // ---------------- memories and helpers ----------------
    logic [1:0] feat_mem [N_IN];
    logic [1:0] wgt_mem  [N_IN*N_OUT];

    function automatic int tern(input logic [1:0] v);
        case (v)
            2'b01:   return 1;
            2'b11:   return -1;
            default: return 0;
        endcase
    endfunction

    function automatic int sat8(input int x);
        if (x > 127)  return 127;
        if (x < -128) return -128;
        return x;
    endfunction

    function automatic int model_score(input int n);
        int s;
        s = 0;
        for (int k = 0; k < N_IN; k++)
            s += tern(feat_mem[k]) * tern(wgt_mem[n*N_IN + k]);
        return sat8(s);
    endfunction

    always @(posedge clk) begin
        i_feat_data <= (int'(o_feat_addr) < N_IN) ? feat_mem[int'(o_feat_addr)] : 2'b00;
        i_wgt_data  <= (int'(o_wgt_addr) < N_IN*N_OUT) ? wgt_mem[int'(o_wgt_addr)] : 2'b00;
    end

    // ---------------- fc_layer stub ----------------
    bit stub_never = 1'b0;
    int acc, beats, cd;
    always @(posedge clk) begin
        if (!resetn) begin
            acc = 0; beats = 0; cd = 0;
            i_fc_real <= 1'b0;
            i_fc_data <= 8'd0;
        end else if (o_fc_valid) begin
            if (beats == 0) begin
                acc = 0;
                i_fc_real <= 1'b0;
            end
            acc += tern(o_fc_data) * tern(o_fc_weight);
            beats++;
            if (beats == N_IN) begin
                beats = 0;
                cd = FC_LAT - 1;
            end
        end else if (cd > 0) begin
            cd--;
            if (cd == 0 && !stub_never) begin
                i_fc_real <= 1'b1;
                i_fc_data <= 8'(sat8(acc));
            end
        end
    end

    // ---------------- monitor ----------------
    int   res_idx_q[$], res_dat_q[$], lat_q[$];
    int   done_cnt, burst_cnt, beat_cnt, stream_err, wlo9, whi9, min_gap, gap_run, since_last;
    logic prev_valid = 1'b0, prev_busy = 1'b0;
    logic [FADDR_W-1:0] prev_faddr = '0;
    logic [WADDR_W-1:0] prev_waddr = '0;

    always @(negedge clk) begin
        int b, n, wa;
        if (!resetn || (o_busy && !prev_busy)) begin
            res_idx_q.delete(); res_dat_q.delete(); lat_q.delete();
            done_cnt = 0; burst_cnt = 0; beat_cnt = 0; stream_err = 0;
            wlo9 = 1 << 30; whi9 = -1; min_gap = 1 << 30; gap_run = 0; since_last = 0;
        end
        if (resetn) begin
            if (o_fc_valid) begin
                b = beat_cnt; n = burst_cnt; wa = n*N_IN + b;
                if (b >= N_IN || n >= N_OUT) stream_err++;
                else if (int'(prev_faddr) != b || int'(prev_waddr) != wa ||
                         o_fc_data !== feat_mem[b] || o_fc_weight !== wgt_mem[wa])
                    stream_err++;
                if (n == N_OUT-1) begin
                    if (int'(prev_waddr) < wlo9) wlo9 = int'(prev_waddr);
                    if (int'(prev_waddr) > whi9) whi9 = int'(prev_waddr);
                end
                if (!prev_valid && n > 0 && gap_run < min_gap) min_gap = gap_run;
                beat_cnt++;
                since_last = 0;
            end else begin
                if (prev_valid) begin
                    if (beat_cnt != N_IN) stream_err++;
                    burst_cnt++;
                    beat_cnt = 0;
                    gap_run = 1;
                end else begin
                    gap_run++;
                end
                since_last++;
            end
            if (o_res_valid) begin
                res_idx_q.push_back(int'(o_res_idx));
                res_dat_q.push_back(int'($signed(o_res_data)));
                lat_q.push_back(since_last);
            end
            if (o_done) done_cnt++;
        end
        prev_valid = o_fc_valid;
        prev_busy  = o_busy;
        prev_faddr = o_feat_addr;
        prev_waddr = o_wgt_addr;
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load_mem(input int fpat, input int wpat, input int hi);
        for (int k = 0; k < N_IN; k++) begin
            case (fpat)
                P_ONE:   feat_mem[k] = 2'b01;
                P_ZERO:  feat_mem[k] = 2'b00;
                default: feat_mem[k] = 2'($urandom_range(0, 3));
            endcase
        end
        for (int a = 0; a < N_IN*N_OUT; a++) begin
            case (wpat)
                W_ONE:   wgt_mem[a] = 2'b01;
                W_ROW:   wgt_mem[a] = ((a / N_IN) == hi) ? 2'b01 : 2'b11;
                W_POS:   wgt_mem[a] = ($urandom_range(0, 9) < 8) ? 2'b01 : 2'b11;
                default: wgt_mem[a] = 2'($urandom_range(0, 3));
            endcase
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int exp_s[N_OUT];
        int ec, best, cyc;
        bit ee;
        load_mem(v.fpat, v.wpat, v.hi_idx);
        stub_never = v.never;
        if (v.use_model) begin
            best = -128; ec = 0;
            for (int n = 0; n < N_OUT; n++) begin
                exp_s[n] = v.never ? -128 : model_score(n);
                if (exp_s[n] > best) begin best = exp_s[n]; ec = n; end
            end
        end else begin
            for (int n = 0; n < N_OUT; n++) exp_s[n] = (n == v.hi_idx) ? v.exp_hi : v.exp_lo;
            ec = v.exp_class;
        end
        ee = v.never;

        @(negedge clk); i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        check("busy_after_start", int'(o_busy), 1);
        cyc = 0;
        while (!o_done && cyc < BUDGET) begin
            i_start = v.spam && ((cyc % 211) == 17);
            @(negedge clk);
            cyc++;
        end
        i_start = 1'b0;
        check("done_seen", int'(o_done), 1);
        check("busy_at_done", int'(o_busy), 0);
        check("class", int'(o_class), ec);
        check("error", int'(o_error), int'(ee));
        check("res_count", res_idx_q.size(), N_OUT);
        for (int i = 0; i < res_idx_q.size() && i < N_OUT; i++) begin
            check($sformatf("res_idx[%0d]", i), res_idx_q[i], i);
            check($sformatf("res_data[%0d]", i), res_dat_q[i], exp_s[i]);
        end
        check("bursts", burst_cnt, N_OUT);
        check("beat_stream_errors", stream_err, 0);
        check("wgt_lo_n9", wlo9, (N_OUT-1)*N_IN);
        check("wgt_hi_n9", whi9, N_OUT*N_IN - 1);
        check("gap_at_least_GAP", int'(min_gap >= GAP), 1);
        if (lat_q.size() > 0) begin
            if (v.never) check("timeout_capture_latency", lat_q[0], TIMEOUT + 1);
            else check("capture_after_rise", int'(lat_q[0] > FC_LAT && lat_q[0] <= FC_LAT + 2), 1);
        end
        @(negedge clk);
        check("done_one_cycle", int'(o_done), 0);
        check("class_hold", int'(o_class), ec);
        repeat (30) @(negedge clk);
        check("no_restart_busy", int'(o_busy), 0);
        check("done_pulses", done_cnt, 1);
        $display("vector %0d: class=%0d error=%0d results=%0d", id, o_class, o_error, res_idx_q.size());
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, int'(o_busy), 0);
        check({tag, "_done"}, int'(o_done), 0);
        check({tag, "_fc_valid"}, int'(o_fc_valid), 0);
        check({tag, "_res_valid"}, int'(o_res_valid), 0);
        check({tag, "_res_data"}, int'(o_res_data), 0);
        check({tag, "_feat_addr"}, int'(o_feat_addr), 0);
        check({tag, "_wgt_addr"}, int'(o_wgt_addr), 0);
        check({tag, "_class"}, int'(o_class), 0);
        check({tag, "_error"}, int'(o_error), 0);
    endtask

    initial begin
        vec_t vt[9];
        vec_t vr;
        int   cyc;
        vt[0] = '{P_ONE,  W_ONE,  0, 0, 0, 0, 127,  127,  0, 0};
        vt[1] = '{P_ONE,  W_ROW,  0, 0, 0, 7, 127,  -128, 7, 0};
        vt[2] = '{P_ZERO, W_RAND, 0, 0, 0, 0, 0,    0,    0, 0};
        vt[3] = '{P_ONE,  W_ONE,  1, 0, 0, 0, -128, -128, 0, 1};
        vt[4] = '{P_RAND, W_RAND, 0, 1, 1, 0, 0,    0,    0, 0};
        vt[5] = '{P_RAND, W_RAND, 0, 0, 1, 0, 0,    0,    0, 0};
        vt[6] = '{P_ONE,  W_RAND, 0, 1, 1, 0, 0,    0,    0, 0};
        vt[7] = '{P_RAND, W_POS,  0, 0, 1, 0, 0,    0,    0, 0};
        vt[8] = '{P_ONE,  W_ONE,  0, 0, 0, 0, 127,  127,  0, 0};
        vr    = '{P_RAND, W_RAND, 0, 0, 1, 0, 0,    0,    0, 0};

        load_mem(P_ZERO, W_ONE, 0);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(vt[i], i);

        // Abort in neuron 3's ISSUE phase, then a clean rerun.
        load_mem(P_RAND, W_RAND, 0);
        stub_never = 1'b0;
        @(negedge clk); i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        cyc = 0;
        while (!(burst_cnt == 3 && beat_cnt >= 40) && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_point_reached", int'(cyc < BUDGET), 1);
        check("res_before_abort", res_idx_q.size(), 3);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("abort");
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_resume", int'(o_busy), 0);
        check("abort_no_results", res_idx_q.size(), 0);
        check("abort_no_done", done_cnt, 0);
        $display("abort: reset applied in neuron 3 after %0d cycles", cyc);
        run_vec(vr, 9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
